// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
// Holds the FSM state encoding and the field layout of the EX/MEM mem_control bits.
// Imported by the controller, its timeout counter and the bus interface users.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Bit positions inside mem_ctl: [1]=MemRead, [0]=MemWrite
   localparam int MEMCTL_RD_BIT = 1;
   localparam int MEMCTL_WR_BIT = 0;

   localparam logic [1:0] CTL_NONE  = 2'b00;
   localparam logic [1:0] CTL_STORE = 2'b01;
   localparam logic [1:0] CTL_LOAD  = 2'b10;
   localparam logic [1:0] CTL_BOTH  = 2'b11;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side (EX/MEM) inputs and data-memory bus of the MEM-stage controller.
// Ports: mem_valid/mem_ctl/mem_addr/mem_wdata from EX/MEM; dmem_req/we/addr/wdata
// to the bus; dmem_gnt/rvalid/rdata back from the bus. master = controller side.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              mem_valid;
   logic [1:0]        mem_ctl;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic              dmem_gnt;
   logic              dmem_rvalid;
   logic [31:0]       dmem_rdata;

   modport master (
      input  mem_valid, mem_ctl, mem_addr, mem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata
   );

   modport slave (
      output mem_valid, mem_ctl, mem_addr, mem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata
   );
endinterface

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// Access timeout counter: 8-bit, cleared when a bus access starts, counts REQ/WAIT cycles.
// Ports: clk_i, reset_i (sync active-low), clr_i, en_i, expire_o (count == TIMEOUT_CYCLES-1).
// expire_o is combinational from the count register; clr_i wins over en_i.
module mem_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam logic [7:0] EXPIRE_CNT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = 8'd0;
      else if (en_i)
         count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i)
         count_q <= 8'd0;
      else
         count_q <= count_d;
   end

   assign expire_o = (count_q == EXPIRE_CNT);
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: req/gnt/rvalid handshake, pipeline stall, load capture.
// Ports: clk_i, reset_i (sync active-low), bus (EX/MEM + dmem), mem_stall_o, load_data_o,
// access_done_o / access_err_o (1-cycle retire pulses). Misaligned, read+write and timed-out accesses flag an error.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic                clk_i,
   input  logic                reset_i,
   mem_access_ctrl_if.master   bus,
   output logic                mem_stall_o,
   output logic [31:0]         load_data_o,
   output logic                access_done_o,
   output logic                access_err_o
);
   state_e            state_q, state_d;
   logic              err_q, err_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       load_q, load_d;
   logic              ctr_clr, ctr_en, expire;
   logic              is_load, is_store, start, bad;

   assign is_load  = (bus.mem_ctl == CTL_LOAD);
   assign is_store = (bus.mem_ctl == CTL_STORE);
   assign start    = bus.mem_valid & (is_load | is_store);
   // Read+write together is never a legal encoding; misaligned word access is refused.
   assign bad      = (start & (bus.mem_addr[1:0] != 2'b00)) |
                     (bus.mem_valid & (bus.mem_ctl == CTL_BOTH));

   mem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clr_i    (ctr_clr),
      .en_i     (ctr_en),
      .expire_o (expire)
   );

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      load_d  = load_q;
      ctr_clr = 1'b0;
      ctr_en  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bad) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else if (start) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               we_d    = bus.mem_ctl[MEMCTL_WR_BIT];
               addr_d  = {bus.mem_addr[ADDR_W-1:2], 2'b00};
               wdata_d = bus.mem_wdata;
               ctr_clr = 1'b1;
            end
         end
         ST_REQ: begin
            ctr_en = 1'b1;
            // A grant on the last allowed cycle still completes the access.
            if (bus.dmem_gnt) begin
               req_d = 1'b0;
               if (we_q) begin
                  state_d = ST_DONE;
               end else if (bus.dmem_rvalid) begin
                  load_d  = bus.dmem_rdata;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (expire) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WAIT: begin
            ctr_en = 1'b1;
            if (bus.dmem_rvalid) begin
               load_d  = bus.dmem_rdata;
               state_d = ST_DONE;
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         load_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         load_q  <= load_d;
      end
   end

   assign bus.dmem_req   = req_q;
   assign bus.dmem_we    = we_q;
   assign bus.dmem_addr  = addr_q;
   assign bus.dmem_wdata = wdata_q;
   assign load_data_o    = load_q;
   assign access_done_o  = (state_q == ST_DONE);
   assign access_err_o   = (state_q == ST_DONE) & err_q;

   // The stall is held low during reset so the pipeline is never frozen by a stale decode.
   assign mem_stall_o = reset_i &
                        (((state_q == ST_IDLE) & (start | bad)) |
                         (state_q == ST_REQ) | (state_q == ST_WAIT));
endmodule
